cfg_serial_tx: RTL
==================

# cfg_serial_tx

Serial configuration transmitter: the initiating end of the SCK/SDA control link that loads the capture engine's register file (trigger mode, thresholds, depth, pre-trigger count, delay, control word). It accepts one 8-bit register address and one 16-bit data word per request and shifts them out MSB-first as a 24-bit frame. It is clocked from the main clock and gives a frame-enable strobe so the receiving side can resynchronise. It sits between the configuration sequencer (or a test-bench host) and the SCK/SDA pins of the FIFO/capture device.

## Interface
Parameters:
- DIV, 4: SCK half-period in Mclk cycles; legal range 1..255.
- ABITS, 8: address field width.
- DBITS, 16: data field width; frame length N = ABITS+DBITS (24 by default).

Ports:
- Mclk  input  1  main clock, rising edge; all logic single-clock.
- nReset  input  1  synchronous, active-low reset, sampled on Mclk rising edge.
- Start  input  1  request; accepted on a rising Mclk edge when Busy=0.
- Addr  input  ABITS  register address; captured on acceptance.
- Data  input  DBITS  register data; captured on acceptance.
- Busy  output  1  high from the cycle after acceptance until frame completion.
- Done  output  1  one-cycle pulse at frame completion.
- SCK  output  1  serial clock; idle low; receiver samples SDA on rising edge.
- SDA  output  1  serial data, MSB first; idle low.
- SEN  output  1  frame enable; high for the whole frame.

## Operation
- Reset (nReset=0 at an edge): SCK=0, SDA=0, SEN=0, Busy=0, Done=0, state=IDLE, shift register and counters cleared. Reset during a frame aborts it at once with no Done. The SEN fall is the receiver's resync cue.
- States:
  - IDLE: on Start → load shift register {Addr,Data}, bit counter=N-1, go to LOW. Busy=1, SEN=1, SDA=shift MSB, SCK=0.
  - LOW: SCK=0 for DIV cycles, then go to HIGH with SCK=1.
  - HIGH: SCK=1 for DIV cycles. Then:
    - if bit counter≠0: shift left by one, decrement the counter, set SDA=new MSB, SCK=0, go to LOW.
    - else: SCK=0, SDA=0, SEN=0, go to GAP.
  - GAP: hold all lines low for DIV cycles. Then pulse Done for one cycle, set Busy=0, go to IDLE.
- SDA changes only on Mclk edges where SCK goes low (or at frame start). It is therefore stable for DIV cycles on each side of every SCK rising edge.
- Start while Busy=1 is ignored, with no queuing. Addr and Data changes after acceptance have no effect.
- The Done cycle is IDLE, so a Start in that cycle is accepted. Back-to-back frames are separated by exactly DIV idle-low cycles plus one cycle.
- Half-period counter width is 8 bits. The bit counter is ceil(log2(N)) bits. Neither counter ever wraps in legal use.

## Timing
- Cycle 0 is the edge at which Start is sampled while Busy=0.
- From cycle 1: Busy=1, SEN=1, SDA=bit N-1, SCK=0.
- Bit k (k=0 is the MSB) has SCK rising at cycle 1+DIV+2kDIV and SCK falling at cycle 1+2(k+1)DIV.
- Last SCK fall at cycle 1+2N·DIV. SEN and SDA drop on the same edge.
- Done=1 and Busy=0 at cycle 1+(2N+1)·DIV, for exactly one cycle.
- For defaults (DIV=4, N=24): first rise at cycle 5, last fall at 193, Done at 197. Total 24 SCK pulses.
- Output latency from Start to first SCK rise is DIV+1 cycles. All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then idle: nReset=0 for 2 cycles, then 1; no Start → SCK=SDA=SEN=Busy=Done=0 for 300 cycles.
- Single frame, DIV=4: Start with Addr=0x5A, Data=0xC3F0 → exactly 24 SCK rises at cycles 5,13,…,189. Bits sampled at the rises equal 0x5AC3F0 MSB-first. Done pulses at cycle 197 only.
- Start while busy: a second Start with Addr=0xFF at cycle 50 → ignored. Frame bits are still 0x5AC3F0 and exactly one Done occurs.
- Back-to-back: Start held high continuously with Addr=0x01/Data=0x0001 → second frame's SEN rises at cycle 198. The gap has SEN=0 for DIV+1 cycles and both frames decode correctly.
- Reset mid-frame: nReset=0 at cycle 100 → all outputs 0 at cycle 101 and no Done. A new Start after release gives a complete correct frame.
- DIV=1 edge case: Addr=0x80, Data=0x0001 → SCK toggles every cycle, first rise at cycle 2, Done at cycle 50. Decoded value is 0x800001.

Source files
------------

// File: rtl/cfg_serial_tx.sv
// ============================================================================
// cfg_serial_tx : shifts {Addr,Data} out MSB-first on SCK/SDA with SEN framing
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cfg_serial_tx #(
  parameter int DIV   = 4,
  parameter int ABITS = 8,
  parameter int DBITS = 16
) (
  input  logic             Mclk,
  input  logic             nReset,
  input  logic             Start,
  input  logic [ABITS-1:0] Addr,
  input  logic [DBITS-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic             SCK,
  output logic             SDA,
  output logic             SEN
);

  localparam int             N        = ABITS + DBITS;
  localparam int             BCW      = $clog2(N);
  localparam logic [7:0]     HALF_M1  = 8'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     hcnt_q, hcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           sck_q, sck_d;
  logic           sda_q, sda_d;
  logic           sen_q, sen_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge Mclk) begin
    if (!nReset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      sda_q   <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      sda_q   <= sda_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    sda_d   = sda_q;
    sen_d   = sen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          shreg_d = {Addr, Data};
          bcnt_d  = BIT_LAST;
          hcnt_d  = HALF_M1;
          busy_d  = 1'b1;
          sen_d   = 1'b1;
          sda_d   = shreg_d[N-1];
          sck_d   = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (hcnt_q == 8'd0) begin
          hcnt_d  = HALF_M1;
          sck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (hcnt_q == 8'd0) begin
          hcnt_d = HALF_M1;
          sck_d  = 1'b0;
          // SDA only moves on the SCK falling edge, keeping it centred on the rise
          if (bcnt_q != '0) begin
            shreg_d = shreg_q << 1;
            bcnt_d  = bcnt_q - BIT_ONE;
            sda_d   = shreg_d[N-1];
            state_d = LOW;
          end else begin
            sda_d   = 1'b0;
            sen_d   = 1'b0;
            state_d = GAP;
          end
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      GAP: begin
        if (hcnt_q == 8'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign SCK  = sck_q;
  assign SDA  = sda_q;
  assign SEN  = sen_q;

endmodule

`default_nettype wire
